// File: rtl/hsid_pkg.sv
// Shared types and sizing constants for the hsid accelerator blocks.
package hsid_pkg;

   localparam int HSID_WORD_WIDTH          = 32;
   localparam int HSID_DATA_WIDTH          = 16;
   localparam int HSID_MAX_HSP_BANDS       = 128;
   localparam int HSID_MAX_HSP_LIBRARY     = 16;
   localparam int HSID_STREAMER_FIFO_DEPTH = 2;
   localparam int HSID_BUS_ADDR_WIDTH      = 32;

   typedef enum logic [2:0] {
      IDLE,
      PIXEL,
      LIBRARY,
      DRAIN,
      DONE
   } hsid_streamer_state_t;

endpackage

// File: rtl/hsid_fifo.sv
// Synchronous FIFO, head visible on o_head_dat the cycle after the write lands.
// Push into a full FIFO is accepted only alongside a pop; clear empties it in one cycle.
module hsid_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_clear,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_dat,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head_dat,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full     = (r_count == (AW+1)'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_head_dat = r_mem[r_rptr];
   assign w_pop_ok   = i_pop && !o_empty;
   assign w_push_ok  = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wptr] <= i_push_dat;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_pop_ok) r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
      end
   end

endmodule

// File: rtl/hsid_vctr_streamer.sv
// Reads the pixel vector then all library vectors over the bus and streams them to hsid_main.
// First element 2 cycles after first grant, 1 word/cycle; downstream stalls throttle reads via FIFO credits.
module hsid_vctr_streamer
   import hsid_pkg::*;
#(
   parameter int WORD_WIDTH       = HSID_WORD_WIDTH,
   parameter int DATA_WIDTH       = HSID_DATA_WIDTH,
   parameter int HSI_BANDS        = HSID_MAX_HSP_BANDS,
   parameter int HSI_LIBRARY_SIZE = HSID_MAX_HSP_LIBRARY,
   parameter int ADDR_WIDTH       = HSID_BUS_ADDR_WIDTH,
   parameter int FIFO_DEPTH       = HSID_STREAMER_FIFO_DEPTH
)(
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic                                clear,
   input  logic [ADDR_WIDTH-1:0]               pixel_addr_in,
   input  logic [ADDR_WIDTH-1:0]               library_addr_in,
   input  logic [$clog2(HSI_BANDS)-1:0]        hsi_bands_in,
   input  logic [$clog2(HSI_LIBRARY_SIZE)-1:0] library_size_in,
   output logic                                mem_req,
   output logic [ADDR_WIDTH-1:0]               mem_addr,
   input  logic                                mem_gnt,
   input  logic                                mem_rvalid,
   input  logic [WORD_WIDTH-1:0]               mem_rdata,
   output logic [WORD_WIDTH-1:0]               hsi_vctr_out,
   output logic                                hsi_vctr_out_valid,
   input  logic                                hsi_vctr_out_ready,
   output logic                                idle,
   output logic                                busy,
   output logic                                done
);

   localparam int BW = $clog2(HSI_BANDS);
   localparam int LW = $clog2(HSI_LIBRARY_SIZE);
   localparam int CW = BW + LW + 1;
   localparam int OW = $clog2(FIFO_DEPTH) + 1;

   hsid_streamer_state_t r_state, w_state_nxt;

   logic [ADDR_WIDTH-1:0] r_addr, r_lib_base;
   logic [CW-1:0]         r_wpv, r_lib_words, r_total, r_cnt, r_popped;
   logic [CW-1:0]         w_wpv, w_lib_words, w_total;
   logic [OW-1:0]         r_outstanding, w_out_nxt, w_fifo_count;
   logic [OW:0]           w_used;
   logic                  r_req_pend, r_abort;
   logic                  w_zero_cfg, w_start, w_clear, w_active, w_credit;
   logic                  w_mem_req, w_gnt, w_rv_acc, w_push, w_pop;
   logic                  w_fifo_clr, w_fifo_empty, w_fifo_full, w_last_pop;
   logic                  w_busy, w_done;
   logic [WORD_WIDTH-1:0] w_push_dat;

   assign w_wpv       = CW'(({1'b0, hsi_bands_in} + (BW+1)'(1)) >> 1);
   assign w_lib_words = w_wpv * CW'(library_size_in);
   assign w_total     = w_wpv + w_lib_words;
   assign w_zero_cfg  = (hsi_bands_in == '0) || (library_size_in == '0);
   assign w_start     = start && !clear && (r_state == IDLE);
   assign w_clear     = clear && (r_state != IDLE);

   // Counting the same-cycle pop as a free slot keeps 1 word/cycle with a 2-deep FIFO.
   assign w_active  = (r_state == PIXEL) || (r_state == LIBRARY);
   assign w_pop     = !w_fifo_empty && hsi_vctr_out_ready;
   assign w_used    = (OW+1)'(r_outstanding) + (OW+1)'(w_fifo_count) - (OW+1)'(w_pop);
   assign w_credit  = w_used < (OW+1)'(FIFO_DEPTH);
   assign w_mem_req = w_active && (r_req_pend || w_credit);
   assign w_gnt     = w_mem_req && mem_gnt;

   // Responses with nothing outstanding belong to a transfer killed by reset.
   assign w_rv_acc   = mem_rvalid && (r_outstanding != '0);
   assign w_push     = w_rv_acc && !r_abort && (!w_fifo_full || w_pop);
   assign w_out_nxt  = r_outstanding + OW'(w_gnt) - OW'(w_rv_acc);
   assign w_fifo_clr = w_clear || r_abort;
   assign w_last_pop = w_pop && (r_popped == r_total - CW'(1));
   assign w_push_dat = {mem_rdata[WORD_WIDTH-1:DATA_WIDTH], mem_rdata[DATA_WIDTH-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (w_start) w_state_nxt = w_zero_cfg ? DONE : PIXEL;
         end
         PIXEL:   if (w_gnt && (r_cnt == r_wpv - CW'(1)))       w_state_nxt = LIBRARY;
         LIBRARY: if (w_gnt && (r_cnt == r_lib_words - CW'(1))) w_state_nxt = DRAIN;
         DRAIN: begin
            if (r_abort) begin
               if (w_out_nxt == '0) w_state_nxt = IDLE;
            end else if (w_last_pop) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_clear) w_state_nxt = DRAIN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr        <= '0;
         r_lib_base    <= '0;
         r_wpv         <= '0;
         r_lib_words   <= '0;
         r_total       <= '0;
         r_cnt         <= '0;
         r_popped      <= '0;
         r_outstanding <= '0;
         r_req_pend    <= 1'b0;
         r_abort       <= 1'b0;
      end else begin
         if (w_start) begin
            r_addr      <= pixel_addr_in;
            r_lib_base  <= library_addr_in;
            r_wpv       <= w_wpv;
            r_lib_words <= w_lib_words;
            r_total     <= w_total;
            r_cnt       <= '0;
         end else if (w_gnt) begin
            if ((r_state == PIXEL) && (r_cnt == r_wpv - CW'(1))) begin
               r_addr <= r_lib_base;
               r_cnt  <= '0;
            end else begin
               r_addr <= r_addr + ADDR_WIDTH'(4);
               r_cnt  <= r_cnt + CW'(1);
            end
         end

         if (w_start)    r_popped <= '0;
         else if (w_pop) r_popped <= r_popped + CW'(1);

         r_outstanding <= w_out_nxt;
         // An ungranted request stays up so address and req never change before gnt.
         r_req_pend    <= w_mem_req && !mem_gnt && !clear;

         if (w_clear)                                      r_abort <= 1'b1;
         else if ((r_state == DRAIN) && (w_out_nxt == '0)) r_abort <= 1'b0;
      end
   end

   hsid_fifo #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (w_fifo_clr),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .o_head_dat (hsi_vctr_out),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_count    (w_fifo_count)
   );

   assign mem_req            = w_mem_req;
   assign mem_addr           = r_addr;
   assign hsi_vctr_out_valid = !w_fifo_empty;
   assign busy               = w_busy;
   assign idle               = !w_busy;
   assign done               = w_done;

endmodule

// File: tb/tb_hsid_vctr_streamer.sv
// Scoreboard bench for hsid_vctr_streamer: bus responder, random sink and address/data queues.
module tb_hsid_vctr_streamer;
   import hsid_pkg::*;

   localparam int AW    = 32;
   localparam int WW    = 32;
   localparam int DEPTH = 2;
   localparam int BW    = $clog2(HSID_MAX_HSP_BANDS);
   localparam int LW    = $clog2(HSID_MAX_HSP_LIBRARY);

   logic          clk = 1'b0;
   logic          rst_n, start, clear;
   logic [AW-1:0] pixel_addr_in, library_addr_in;
   logic [BW-1:0] hsi_bands_in;
   logic [LW-1:0] library_size_in;
   logic          mem_req, mem_gnt, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [WW-1:0] mem_rdata, hsi_vctr_out;
   logic          hsi_vctr_out_valid, hsi_vctr_out_ready;
   logic          idle, busy, done;

   always #5 clk = ~clk;

   hsid_vctr_streamer #(
      .WORD_WIDTH(WW), .DATA_WIDTH(16), .HSI_BANDS(HSID_MAX_HSP_BANDS),
      .HSI_LIBRARY_SIZE(HSID_MAX_HSP_LIBRARY), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .pixel_addr_in(pixel_addr_in), .library_addr_in(library_addr_in),
      .hsi_bands_in(hsi_bands_in), .library_size_in(library_size_in),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .hsi_vctr_out(hsi_vctr_out), .hsi_vctr_out_valid(hsi_vctr_out_valid),
      .hsi_vctr_out_ready(hsi_vctr_out_ready),
      .idle(idle), .busy(busy), .done(done)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mdat(input logic [31:0] a);
      return {~a[15:0], a[15:0] ^ 16'h5A5A};
   endfunction

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_dat_q[$];
   logic [31:0] rsp_q[$];
   bit          rand_mode = 0;
   bit          rv_hold   = 0;
   int cyc = 0, start_cyc, first_req_cyc, first_gnt_cyc, first_vld_cyc, last_hs_cyc, done_cyc;
   int done_cnt, n_reads, n_words, n_req_cycles, n_rvalid, inflight, max_inflight, stall_err;
   int gnt_wait;
   bit held, prev_pend;
   logic [31:0] held_dat, prev_addr;

   task automatic clr_stats();
      first_req_cyc = -1; first_gnt_cyc = -1; first_vld_cyc = -1;
      last_hs_cyc = -1; done_cyc = -1; start_cyc = -1;
      done_cnt = 0; n_reads = 0; n_words = 0; n_req_cycles = 0; n_rvalid = 0;
      inflight = 0; max_inflight = 0; stall_err = 0; gnt_wait = 0;
   endtask

   // Bus responder, stream sink and monitor; observations are taken 2 time units after the negedge.
   initial begin
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; hsi_vctr_out_ready = 0;
      held = 0; prev_pend = 0; held_dat = '0; prev_addr = '0;
      clr_stats();
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            mem_gnt = 0; mem_rvalid = 0; hsi_vctr_out_ready = 0;
            rsp_q.delete(); held = 0; prev_pend = 0;
            continue;
         end
         mem_rvalid = 0;
         if (!rv_hold && rsp_q.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
            mem_rvalid = 1;
            mem_rdata  = rsp_q.pop_front();
            n_rvalid++;
         end
         hsi_vctr_out_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
         #1;
         mem_gnt = 0;
         if (mem_req) begin
            if (gnt_wait > 0) gnt_wait--;
            else mem_gnt = 1;
         end
         #1;
         if (start && idle && !clear) begin
            start_cyc = cyc; first_req_cyc = -1; first_gnt_cyc = -1; first_vld_cyc = -1;
         end
         if (mem_req) begin
            n_req_cycles++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
         end
         if (prev_pend && mem_req && mem_addr !== prev_addr) stall_err++;
         prev_pend = mem_req && !mem_gnt;
         prev_addr = mem_addr;
         if (mem_req && mem_gnt) begin
            n_reads++;
            inflight++;
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            if (exp_addr_q.size() == 0) check("read_extra", 0, 1);
            else check("read_addr", mem_addr, exp_addr_q.pop_front());
            rsp_q.push_back(mdat(mem_addr));
            gnt_wait = rand_mode ? $urandom_range(0, 3) : 0;
         end
         if (hsi_vctr_out_valid && held && hsi_vctr_out !== held_dat) stall_err++;
         held     = hsi_vctr_out_valid && !hsi_vctr_out_ready;
         held_dat = hsi_vctr_out;
         if (hsi_vctr_out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
         if (hsi_vctr_out_valid && hsi_vctr_out_ready) begin
            n_words++;
            inflight--;
            if (exp_dat_q.size() == 0) check("word_extra", 0, 1);
            else begin
               check("word_dat", hsi_vctr_out, exp_dat_q.pop_front());
               if (exp_dat_q.size() == 0) last_hs_cyc = cyc;
            end
         end
         if (inflight > max_inflight) max_inflight = inflight;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic start_run(input logic [31:0] pix, input logic [31:0] lib, input int bands, input int lsz);
      int wpv;
      clr_stats();
      exp_addr_q.delete();
      exp_dat_q.delete();
      wpv = (bands + 1) >> 1;
      if (bands != 0 && lsz != 0) begin
         for (int k = 0; k < wpv; k++) begin
            exp_addr_q.push_back(pix + 32'(4 * k));
            exp_dat_q.push_back(mdat(pix + 32'(4 * k)));
         end
         for (int n = 0; n < wpv * lsz; n++) begin
            exp_addr_q.push_back(lib + 32'(4 * n));
            exp_dat_q.push_back(mdat(lib + 32'(4 * n)));
         end
      end
      @(negedge clk);
      pixel_addr_in   = pix;
      library_addr_in = lib;
      hsi_bands_in    = BW'(bands);
      library_size_in = LW'(lsz);
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #3;
         if (done_cnt > 0) break;
      end
      check({tag, "_done_seen"}, done_cnt > 0, 1);
   endtask

   task automatic check_run(input string tag, input int reads);
      repeat (3) @(negedge clk);
      #3;
      check({tag, "_reads"}, n_reads, reads);
      check({tag, "_words"}, n_words, reads);
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_done_lat"}, done_cyc, last_hs_cyc + 1);
      check({tag, "_credit"}, max_inflight <= DEPTH, 1);
      check({tag, "_stable"}, stall_err, 0);
      check({tag, "_idle"}, idle, 1);
   endtask

   int words_at_clear;

   initial begin
      rst_n = 0; start = 0; clear = 0;
      pixel_addr_in = '0; library_addr_in = '0; hsi_bands_in = '0; library_size_in = '0;
      #23;
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_out", hsi_vctr_out, 0);
      check("rst_vld", hsi_vctr_out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_idle", idle, 1);
      @(negedge clk);
      rst_n = 1;

      // 8 bands, 3 vectors, everything tied high
      start_run(32'h100, 32'h200, 8, 3);
      wait_done("a");
      check("a_req_lat", first_req_cyc, start_cyc + 1);
      check("a_vld_lat", first_vld_cyc, first_gnt_cyc + 2);
      check("a_rate", last_hs_cyc - first_vld_cyc, 15);
      check_run("a", 16);

      // same config with random grant delay, rvalid delay and ready
      rand_mode = 1;
      start_run(32'h100, 32'h200, 8, 3);
      wait_done("b");
      check_run("b", 16);
      rand_mode = 0;

      // odd band count; a second start mid-transfer must be ignored
      start_run(32'h100, 32'h200, 7, 1);
      repeat (2) @(negedge clk);
      pixel_addr_in = 32'h900; library_addr_in = 32'hA00; hsi_bands_in = 4; library_size_in = 2;
      start = 1;
      @(negedge clk);
      start = 0;
      wait_done("c");
      check_run("c", 8);

      // empty library
      start_run(32'h100, 32'h200, 8, 0);
      wait_done("d");
      check("d_no_req", n_req_cycles, 0);
      check("d_done_lat", done_cyc, start_cyc + 1);
      check("d_words", n_words, 0);
      @(negedge clk);
      #3;
      check("d_idle_back", idle, 1);

      // abort with two reads in flight
      start_run(32'h100, 32'h200, 8, 3);
      for (int i = 0; i < 500 && n_words < 5; i++) begin
         @(negedge clk);
         #3;
      end
      rv_hold = 1;
      for (int i = 0; i < 500 && !((n_reads - n_rvalid) == 2 && !hsi_vctr_out_valid); i++) begin
         @(negedge clk);
         #3;
      end
      check("e_two_outstanding", n_reads - n_rvalid, 2);
      @(negedge clk);
      clear = 1;
      words_at_clear = n_words;
      @(negedge clk);
      clear = 0;
      #3;
      check("e_vld_low", hsi_vctr_out_valid, 0);
      check("e_req_low", mem_req, 0);
      rv_hold = 0;
      for (int i = 0; i < 200 && !idle; i++) begin
         @(negedge clk);
         #3;
      end
      repeat (3) @(negedge clk);
      #3;
      check("e_idle", idle, 1);
      check("e_rsp_absorbed", rsp_q.size(), 0);
      check("e_vld_after", hsi_vctr_out_valid, 0);
      check("e_no_words", n_words, words_at_clear);
      check("e_no_done", done_cnt, 0);
      start_run(32'h100, 32'h200, 8, 3);
      wait_done("e2");
      check_run("e2", 16);

      // reset in the middle of the library phase
      start_run(32'h100, 32'h200, 8, 3);
      for (int i = 0; i < 500 && n_reads < 6; i++) begin
         @(negedge clk);
         #3;
      end
      #2;
      rst_n = 0;
      #1;
      check("f_req", mem_req, 0);
      check("f_addr", mem_addr, 0);
      check("f_out", hsi_vctr_out, 0);
      check("f_vld", hsi_vctr_out_valid, 0);
      check("f_busy", busy, 0);
      check("f_idle", idle, 1);
      repeat (2) @(negedge clk);
      rst_n = 1;
      start_run(32'h400, 32'h800, 3, 2);
      wait_done("g");
      check_run("g", 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
